// File: rtl/fpu_driver.sv
// rtl/fpu_driver.sv - one-at-a-time initiator for the FPU rdy/ack handshakes
// Issues one upstream request to the FPU, collects its result and returns it
// upstream. A watchdog turns a stalled issue or result wait into an error response.
module fpu_driver #(
    parameter int bitness   = 32,
    parameter int timeout   = 1024,
    parameter int cnt_width = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [bitness-1:0]   i_req_a,
    input  logic [bitness-1:0]   i_req_b,
    input  logic [3:0]           i_req_cmd,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [bitness-1:0]   o_resp_result,
    output logic                 o_resp_error,
    output logic                 o_fpu_input_rdy,
    input  logic                 i_fpu_input_ack,
    input  logic                 i_fpu_output_rdy,
    output logic                 o_fpu_output_ack,
    output logic [bitness-1:0]   o_fpu_data_a,
    output logic [bitness-1:0]   o_fpu_data_b,
    output logic [3:0]           o_fpu_command,
    input  logic [bitness-1:0]   i_fpu_result,
    output logic                 o_busy,
    output logic [cnt_width-1:0] o_job_count
);
    localparam int WD_W = $clog2(timeout);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RES, S_ACK, S_DRAIN, S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_req_ready;
    logic [WD_W-1:0]        r_wd;
    logic [bitness-1:0]     r_data_a;
    logic [bitness-1:0]     r_data_b;
    logic [3:0]             r_command;
    logic [bitness-1:0]     r_resp_result;
    logic                   r_resp_error;
    logic [cnt_width-1:0]   r_job_count;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_wd_expired;

    assign w_wd_expired = (r_wd == WD_W'(timeout - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The awaited FPU event is checked before the watchdog so it wins a tie.
    always_comb begin
        w_next           = r_state;
        w_accept         = 1'b0;
        w_abort          = 1'b0;
        o_resp_valid     = 1'b0;
        o_fpu_input_rdy  = 1'b0;
        o_fpu_output_ack = 1'b0;
        o_busy           = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_fpu_input_rdy = 1'b1;
                if (i_fpu_input_ack) begin
                    w_next = S_WAIT_RES;
                end else if (w_wd_expired) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end
            S_WAIT_RES: begin
                if (i_fpu_output_rdy) begin
                    w_next = S_ACK;
                end else if (w_wd_expired) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end
            S_ACK: begin
                o_fpu_output_ack = 1'b1;
                w_next           = S_DRAIN;
            end
            // Leaving only once output_rdy falls keeps a held result from being taken twice.
            S_DRAIN: begin
                if (!i_fpu_output_rdy) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_req_ready   <= 1'b1;
            r_wd          <= '0;
            r_data_a      <= '0;
            r_data_b      <= '0;
            r_command     <= '0;
            r_resp_result <= '0;
            r_resp_error  <= 1'b0;
            r_job_count   <= '0;
        end else begin
            r_req_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_data_a      <= i_req_a;
                r_data_b      <= i_req_b;
                r_command     <= i_req_cmd;
                r_wd          <= '0;
                r_resp_result <= '0;
                r_resp_error  <= 1'b0;
            end
            if (r_state == S_ISSUE || r_state == S_WAIT_RES) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (r_state == S_WAIT_RES && i_fpu_output_rdy) begin
                r_resp_result <= i_fpu_result;
            end
            if (w_abort) begin
                r_resp_result <= '0;
                r_resp_error  <= 1'b1;
            end
            if (r_state == S_RESP && i_resp_ready && !r_resp_error) begin
                r_job_count <= r_job_count + cnt_width'(1);
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_fpu_data_a  = r_data_a;
    assign o_fpu_data_b  = r_data_b;
    assign o_fpu_command = r_command;
    assign o_resp_result = r_resp_result;
    assign o_resp_error  = r_resp_error;
    assign o_job_count   = r_job_count;
endmodule

// File: tb/tb_fpu_driver.sv
// tb/tb_fpu_driver.sv - randomized check of fpu_driver against a job-level model
// Each job gives the FPU's ack delay d, result delay r, result hold h and upstream stall bp.
module tb_fpu_driver;
    localparam int B  = 32;
    localparam int T  = 16;
    localparam int CW = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  cmd;
        int          d;
        int          r;
        int          h;
        int          bp;
    } job_t;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [B-1:0]  i_req_a;
    logic [B-1:0]  i_req_b;
    logic [3:0]    i_req_cmd;
    logic          o_resp_valid;
    logic          i_resp_ready;
    logic [B-1:0]  o_resp_result;
    logic          o_resp_error;
    logic          o_fpu_input_rdy;
    logic          i_fpu_input_ack;
    logic          i_fpu_output_rdy;
    logic          o_fpu_output_ack;
    logic [B-1:0]  o_fpu_data_a;
    logic [B-1:0]  o_fpu_data_b;
    logic [3:0]    o_fpu_command;
    logic [B-1:0]  i_fpu_result;
    logic          o_busy;
    logic [CW-1:0] o_job_count;

    always #5 i_clock = ~i_clock;

    fpu_driver #(.bitness(B), .timeout(T), .cnt_width(CW)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_cmd(i_req_cmd),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_result(o_resp_result), .o_resp_error(o_resp_error),
        .o_fpu_input_rdy(o_fpu_input_rdy), .i_fpu_input_ack(i_fpu_input_ack),
        .i_fpu_output_rdy(i_fpu_output_rdy), .o_fpu_output_ack(o_fpu_output_ack),
        .o_fpu_data_a(o_fpu_data_a), .o_fpu_data_b(o_fpu_data_b),
        .o_fpu_command(o_fpu_command), .i_fpu_result(i_fpu_result),
        .o_busy(o_busy), .o_job_count(o_job_count)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_jc  = 0;
    job_t pend[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic add_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd,
                           input logic [31:0] res, input int d, input int r, input int h, input int bp);
        job_t j;
        j.a = a; j.b = b; j.cmd = cmd; j.res = res;
        j.d = d; j.r = r; j.h = h; j.bp = bp;
        pend.push_back(j);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
        check({tag, "_input_rdy"}, 64'(o_fpu_input_rdy), 64'd0);
        check({tag, "_output_ack"}, 64'(o_fpu_output_ack), 64'd0);
        check({tag, "_data_a"}, 64'(o_fpu_data_a), 64'd0);
        check({tag, "_result"}, 64'(o_resp_result), 64'd0);
        check({tag, "_job_count"}, 64'(o_job_count), 64'd0);
    endtask

    // Runs the queued jobs; req_valid stays high while more jobs wait.
    task automatic run_pending();
        job_t        j;
        int          guard, wait_in, res_wait, hold_left, n_ack, n_resp, exp_idx;
        bit          acked, presenting, ack_seen, exp_err, done;
        logic [31:0] exp_res;
        while (pend.size() > 0) begin
            j = pend.pop_front();
            i_req_valid = 1'b1;
            i_req_a = j.a; i_req_b = j.b; i_req_cmd = j.cmd;
            guard = 0;
            while (!o_req_ready && guard < 100) begin
                tick();
                guard++;
            end
            check("req_ready_idle", 64'(o_req_ready), 64'd1);
            tick();
            i_req_valid = (pend.size() > 0);
            if (pend.size() > 0) begin
                i_req_a = pend[0].a; i_req_b = pend[0].b; i_req_cmd = pend[0].cmd;
            end

            // Job-level expectation: the FPU result arrives d+1+r cycles after issue
            // begins, and must do so within T cycles of ISSUE+WAIT_RES.
            exp_err = (j.d + j.r + 2 > T);
            exp_res = exp_err ? 32'd0 : j.res;
            exp_idx = exp_err ? T : (j.d + j.r + 3 + ((j.h > 1) ? j.h : 1));

            acked = 0; presenting = 0; ack_seen = 0; done = 0;
            wait_in = 0; res_wait = 0; hold_left = 0; n_ack = 0; n_resp = 0;
            i_resp_ready = 1'b0;
            for (int k = 0; k < 200 && !done; k++) begin
                i_fpu_input_ack = 1'b0;
                if (!acked && o_fpu_input_rdy) begin
                    if (wait_in == j.d) begin
                        i_fpu_input_ack = 1'b1;
                        acked = 1;
                        check("fpu_data_a", 64'(o_fpu_data_a), 64'(j.a));
                        check("fpu_data_b", 64'(o_fpu_data_b), 64'(j.b));
                        check("fpu_command", 64'(o_fpu_command), 64'(j.cmd));
                    end
                    wait_in++;
                end else if (acked && !presenting && !ack_seen) begin
                    if (res_wait == j.r) begin
                        presenting = 1;
                        i_fpu_output_rdy = 1'b1;
                        i_fpu_result = j.res;
                    end
                    res_wait++;
                end
                if (o_fpu_output_ack) begin
                    n_ack++;
                    if (presenting && !ack_seen) begin
                        ack_seen = 1;
                        hold_left = j.h;
                    end
                end
                if (presenting && ack_seen) begin
                    if (hold_left == 0) begin
                        i_fpu_output_rdy = 1'b0;
                        presenting = 0;
                    end else begin
                        hold_left--;
                    end
                end
                if (o_resp_valid) begin
                    if (n_resp == 0) check("resp_latency", 64'(k), 64'(exp_idx));
                    check("resp_result", 64'(o_resp_result), 64'(exp_res));
                    check("resp_error", 64'(o_resp_error), 64'(exp_err));
                    check("req_ready_busy", 64'(o_req_ready), 64'd0);
                    n_resp++;
                    i_resp_ready = (n_resp > j.bp);
                    if (i_resp_ready) done = 1;
                end
                tick();
            end
            check("resp_handshake", 64'(done), 64'd1);
            i_resp_ready = 1'b0;
            i_fpu_input_ack = 1'b0;
            i_fpu_output_rdy = 1'b0;
            if (!exp_err) exp_jc = (exp_jc + 1) % (1 << CW);
            check("output_ack_count", 64'(n_ack), exp_err ? 64'd0 : 64'd1);
            check("resp_valid_after", 64'(o_resp_valid), 64'd0);
            check("busy_after", 64'(o_busy), 64'd0);
            check("req_ready_after", 64'(o_req_ready), 64'd1);
            check("job_count", 64'(o_job_count), 64'(exp_jc));
        end
    endtask

    initial begin
        int nb;
        i_reset = 1'b0;
        i_req_valid = 1'b0; i_req_a = '0; i_req_b = '0; i_req_cmd = '0;
        i_resp_ready = 1'b0; i_fpu_input_ack = 1'b0; i_fpu_output_rdy = 1'b0; i_fpu_result = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        i_reset = 1'b1;
        tick();

        add_job(32'h3F80_0000, 32'h4000_0000, 4'd0, 32'h4040_0000, 1, 7, 0, 0);
        run_pending();
        add_job(32'h1234_5678, 32'h9ABC_DEF0, 4'd3, 32'hCAFE_F00D, 0, 2, 0, 10);
        add_job(32'h0000_0001, 32'hFFFF_FFFF, 4'd15, 32'h0BAD_BEEF, 2, 1, 3, 0);
        add_job(32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd9, 32'h1111_2222, 0, 0, 0, 0);
        run_pending();
        add_job(32'h0000_0002, 32'h0000_0003, 4'd1, 32'h7777_7777, 0, 99, 0, 2);
        run_pending();
        add_job(32'h0000_0004, 32'h0000_0005, 4'd2, 32'h6666_6666, 99, 0, 0, 0);
        run_pending();
        add_job(32'h0000_0006, 32'h0000_0007, 4'd4, 32'h5555_5555, 0, 14, 1, 0);
        run_pending();
        add_job(32'h0000_0008, 32'h0000_0009, 4'd5, 32'h4444_4444, 1, 14, 0, 0);
        run_pending();
        for (int i = 0; i < 4; i++) begin
            add_job($urandom, $urandom, 4'(i + 6), $urandom, i % 2, i, i % 3, 0);
        end
        run_pending();
        add_job($urandom, $urandom, 4'd12, $urandom, 0, 1, 0, 0);
        run_pending();

        i_req_valid = 1'b1; i_req_a = 32'hDEAD_BEEF; i_req_b = 32'h0000_0010; i_req_cmd = 4'd7;
        tick();
        i_req_valid = 1'b0;
        tick();
        tick();
        check("mid_issue_input_rdy", 64'(o_fpu_input_rdy), 64'd1);
        i_reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        i_reset = 1'b1;
        tick();
        check_idle_outputs("post_reset");
        exp_jc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_resp_after_reset", 64'(o_resp_valid), 64'd0);
        end

        for (int n = 0; n < 12; n++) begin
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                add_job($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3),
                        $urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            run_pending();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_driver.md
Name: fpu_driver

Overview:
- Initiator-side companion to the floating point unit.
- Accepts one operation at a time from an upstream requester and presents operands and command to the FPU with the FPU's rdy/ack input handshake.
- Waits for the FPU result, acknowledges it through the FPU's output handshake, and returns the result upstream with a valid/ready response.
- Includes a watchdog timeout and a completed-job counter for software/debug visibility.

Parameters:
- bitness, 32, operand/result width (16/32/64/128/256).
- timeout, 1024, max cycles spent in ISSUE+WAIT_RES before aborting with error; must be >= 2.
- cnt_width, 16, width of job_count.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  driver can accept a request.
- req_a  in  bitness  operand A.
- req_b  in  bitness  operand B.
- req_cmd  in  4  FPU command code, passed through unchanged.
- resp_valid  out  1  response present.
- resp_ready  in  1  upstream takes response.
- resp_result  out  bitness  FPU result; 0 on error.
- resp_error  out  1  response is a timeout abort.
- fpu_input_rdy  out  1  operands valid to FPU.
- fpu_input_ack  in  1  FPU captured operands.
- fpu_output_rdy  in  1  FPU result valid.
- fpu_output_ack  out  1  driver consumed result.
- fpu_data_a  out  bitness  operand A to FPU.
- fpu_data_b  out  bitness  operand B to FPU.
- fpu_command  out  4  command to FPU.
- fpu_result  in  bitness  FPU result bus.
- busy  out  1  state != IDLE.
- job_count  out  cnt_width  successful (non-error) responses delivered; wraps modulo 2^cnt_width.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - All outputs 0 except req_ready=1.
  - Operand/result registers and watchdog cleared.
  - Reset asserted mid-operation abandons the job; no response is produced.
- FSM states: IDLE, ISSUE, WAIT_RES, ACK, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a/req_b/req_cmd into fpu_data_a/b/command, clear watchdog, go to ISSUE.
  - req_ready is registered; it is 0 in every other state.
- ISSUE:
  - fpu_input_rdy=1; fpu_data_*/fpu_command held stable.
  - On sampled fpu_input_ack=1: go to WAIT_RES; fpu_input_rdy=0 from the next cycle.
  - fpu_input_ack is treated as a level.
- WAIT_RES:
  - On sampled fpu_output_rdy=1: capture fpu_result into resp_result, go to ACK.
- ACK:
  - fpu_output_ack=1 for exactly one cycle, then go to DRAIN.
- DRAIN:
  - Wait until fpu_output_rdy=0, then go to RESP.
  - This prevents double-capturing the same result.
  - DRAIN has no timeout.
- RESP:
  - resp_valid=1; resp_result and resp_error held stable until resp_ready=1.
  - On the handshake: resp_valid=0, job_count increments if resp_error=0, go to IDLE.
  - A new request may be accepted at the earliest the cycle after the response handshake.
- Watchdog:
  - Increments every cycle in ISSUE or WAIT_RES.
  - When it reaches timeout-1 without the awaited event: fpu_input_rdy=0, resp_result=0, resp_error=1, go directly to RESP.
  - If the awaited FPU event and timeout occur in the same cycle, the FPU event wins.
- Minimum latency: request accept to resp_valid = 5 cycles with an FPU that acks and responds immediately (IDLE→ISSUE→WAIT_RES→ACK→DRAIN→RESP).
- resp_ready held high while RESP is entered: completes in the first RESP cycle.
- Unknown command codes are forwarded unchanged; the driver does not decode req_cmd.

Test Plan:
- Reset then idle: reset=0 mid-ISSUE → all outputs 0, req_ready=1, busy=0 immediately after reset release.
- Single add: req_a=0x3F800000, req_b=0x40000000, req_cmd=0, FPU model acks after 1 cycle and returns 0x40400000 after 8 cycles → resp_valid with resp_result=0x40400000, resp_error=0, fpu_output_ack high exactly 1 cycle, job_count=1.
- Upstream backpressure: hold resp_ready=0 for 10 cycles → resp_valid, resp_result and resp_error stable throughout; req_ready=0; completes on the cycle resp_ready=1.
- FPU holds fpu_output_rdy high 3 cycles after ack → exactly one capture; driver stays in DRAIN until output_rdy=0; no second response.
- Timeout: timeout=16, FPU never asserts fpu_output_rdy → resp_valid at cycle 16 after entering ISSUE, resp_error=1, resp_result=0, job_count unchanged.
- Back-to-back: 4 queued requests with req_valid always 1 → 4 responses in order, no request lost or duplicated, job_count=4; cnt_width=2 run of 5 jobs → job_count wraps to 1.
